pipe_stage_elastic: RTL and testbench

- Parametrised, elastic successor to the fixed ID/EX register.
- Carries one payload word (data fields) and one control word (EX/MEM/WB control bits) between two pipeline stages.
- Uses a valid/ready handshake, a 2-entry skid buffer, a synchronous flush that injects a bubble, and a saturating stall counter.
- One instance per stage boundary: IF/ID, ID/EX, EX/MEM, MEM/WB.

---
 rtl/pipe_stage_elastic.sv | 107 ++++++++++
 tb/tb_pipe_stage_elastic.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready handshake, 2-entry skid buffer, synchronous
// bubble-injecting flush and a saturating back-pressure counter. All outputs registered.
module pipe_stage_elastic #(
    parameter int unsigned       DATA_W      = 106,
    parameter int unsigned       CTRL_W      = 8,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
    parameter int unsigned       CNT_W       = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;

    logic acc;
    logic pop;

    // Ready depends only on a flop, so there is no combinational path from out_ready_i.
    assign in_ready_o = ~skid_valid_q;
    assign acc        = in_valid_i & in_ready_o;
    assign pop        = main_valid_q & out_ready_i;

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;
        stall_cnt_d  = stall_cnt_q;

        if (flush_i) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = CTRL_BUBBLE;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || pop) begin
            if (skid_valid_q) begin
                // Older skid entry always moves up before anything newer.
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_ctrl_d  = skid_ctrl_q;
                skid_valid_d = 1'b0;
            end else if (acc) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data_i;
                main_ctrl_d  = in_ctrl_i;
            end else begin
                main_valid_d = 1'b0;
                main_ctrl_d  = CTRL_BUBBLE;
            end
        end else if (acc) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
            skid_ctrl_d  = in_ctrl_i;
        end

        // Counting is independent of flush; only reset clears it.
        if (main_valid_q && !out_ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the data registers are cleared too, so outputs are fully defined after reset.
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_ctrl_q  <= CTRL_BUBBLE;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_ctrl_q  <= main_ctrl_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;
    assign out_ctrl_o  = main_ctrl_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: directed scenarios plus randomized
// valid/ready/flush/reset traffic against a queue-based model of the held entries.
module tb_pipe_stage_elastic;

    localparam int unsigned DATA_W = 106;
    localparam int unsigned CTRL_W = 8;
    localparam logic [CTRL_W-1:0] BUBBLE = 8'h00;
    localparam int unsigned CNT_W = 16;
    localparam logic [3:0] S_BUBBLE = 4'h5;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              flush_i = 1'b0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_data_i = '0;
    logic [CTRL_W-1:0] in_ctrl_i = '0;
    logic              out_valid_o;
    logic              out_ready_i = 1'b0;
    logic [DATA_W-1:0] out_data_o;
    logic [CTRL_W-1:0] out_ctrl_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    // Narrow instance used for the counter saturation scenario.
    logic       s_flush = 1'b0;
    logic       s_in_valid = 1'b0;
    logic       s_in_ready;
    logic [7:0] s_in_data = '0;
    logic [3:0] s_in_ctrl = '0;
    logic       s_out_valid;
    logic       s_out_ready = 1'b1;
    logic [7:0] s_out_data;
    logic [3:0] s_out_ctrl;
    logic [3:0] s_cnt;

    pipe_stage_elastic dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_ctrl_i   (in_ctrl_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_ctrl_o  (out_ctrl_o),
        .stall_cnt_o (stall_cnt_o)
    );

    pipe_stage_elastic #(
        .DATA_W      (8),
        .CTRL_W      (4),
        .CTRL_BUBBLE (S_BUBBLE),
        .CNT_W       (4)
    ) sat (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (s_flush),
        .in_valid_i  (s_in_valid),
        .in_ready_o  (s_in_ready),
        .in_data_i   (s_in_data),
        .in_ctrl_i   (s_in_ctrl),
        .out_valid_o (s_out_valid),
        .out_ready_i (s_out_ready),
        .out_data_o  (s_out_data),
        .out_ctrl_o  (s_out_ctrl),
        .stall_cnt_o (s_cnt)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    entry_t          held[$];   // entries the stage currently owns, oldest first
    logic [CNT_W-1:0] exp_cnt = '0;
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: the stage holds up to two entries; accepts while holding fewer than two.
    task automatic model_step();
        bit can_take;
        bit has_out;
        if (rst_i) begin
            held.delete();
            exp_cnt = '0;
        end else begin
            can_take = (held.size() < 2);
            has_out  = (held.size() > 0);
            if (has_out && !out_ready_i && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
            if (flush_i) begin
                held.delete();
            end else begin
                if (has_out && out_ready_i) void'(held.pop_front());
                if (in_valid_i && can_take) held.push_back('{data: in_data_i, ctrl: in_ctrl_i});
            end
        end
    endtask

    task automatic compare_all();
        entry_t head;
        check("out_valid", 128'(out_valid_o), 128'(held.size() > 0));
        check("in_ready", 128'(in_ready_o), 128'(held.size() < 2));
        check("stall_cnt", 128'(stall_cnt_o), 128'(exp_cnt));
        if (held.size() > 0) begin
            head = held[0];
            check("out_data", 128'(out_data_o), 128'(head.data));
            check("out_ctrl", 128'(out_ctrl_o), 128'(head.ctrl));
        end else begin
            check("out_ctrl_bubble", 128'(out_ctrl_o), 128'(BUBBLE));
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
    endtask

    task automatic offer(input int unsigned d, input logic [CTRL_W-1:0] c);
        in_valid_i = 1'b1;
        in_data_i  = DATA_W'(d);
        in_ctrl_i  = c;
    endtask

    initial begin
        logic [127:0] rnd;
        int ready_pct;

        // Reset values
        do_reset();
        check("rst_out_valid", 128'(out_valid_o), 128'(0));
        check("rst_in_ready", 128'(in_ready_o), 128'(1));
        check("rst_out_data", 128'(out_data_o), 128'(0));
        check("rst_cnt", 128'(stall_cnt_o), 128'(0));
        check("rst_sat_ctrl", 128'(s_out_ctrl), 128'(S_BUBBLE));
        check("rst_sat_valid", 128'(s_out_valid), 128'(0));

        // Streaming: one entry per cycle, no stalls
        out_ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            offer(i, CTRL_W'(8'h10 + i));
            cycle();
            check("stream_data", 128'(out_data_o), 128'(i));
            check("stream_ready", 128'(in_ready_o), 128'(1));
        end
        in_valid_i = 1'b0;
        cycle();
        check("stream_cnt", 128'(stall_cnt_o), 128'(0));

        // Back-pressure into the skid register
        do_reset();
        out_ready_i = 1'b0;
        offer(5, 8'h25);
        cycle();
        offer(6, 8'h26);
        cycle();
        check("skid_ready_low", 128'(in_ready_o), 128'(0));
        offer(7, 8'h27);
        cycle();
        check("skid_hold_data", 128'(out_data_o), 128'(5));
        out_ready_i = 1'b1;
        cycle();
        check("drain_6", 128'(out_data_o), 128'(6));
        cycle();
        check("drain_7", 128'(out_data_o), 128'(7));
        in_valid_i = 1'b0;
        cycle();
        check("drain_empty", 128'(out_valid_o), 128'(0));
        check("bp_cnt", 128'(stall_cnt_o), 128'(2));

        // Flush with both entries full and a new offer
        do_reset();
        out_ready_i = 1'b0;
        offer(9, 8'h39);
        cycle();
        offer(10, 8'h3a);
        cycle();
        offer(11, 8'h3b);
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        check("flush_valid", 128'(out_valid_o), 128'(0));
        check("flush_ctrl", 128'(out_ctrl_o), 128'(BUBBLE));
        check("flush_ready", 128'(in_ready_o), 128'(1));
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("flush_gone", 128'(out_valid_o), 128'(0));
        end

        // Reset mid-operation
        do_reset();
        out_ready_i = 1'b0;
        offer(33, 8'h41);
        cycle();
        offer(34, 8'h42);
        cycle();
        in_valid_i = 1'b0;
        cycle();
        cycle();
        check("pre_rst_cnt", 128'(stall_cnt_o), 128'(3));
        check("pre_rst_ready", 128'(in_ready_o), 128'(0));
        do_reset();
        check("mid_rst_valid", 128'(out_valid_o), 128'(0));
        check("mid_rst_ready", 128'(in_ready_o), 128'(1));
        check("mid_rst_ctrl", 128'(out_ctrl_o), 128'(BUBBLE));
        check("mid_rst_data", 128'(out_data_o), 128'(0));
        check("mid_rst_cnt", 128'(stall_cnt_o), 128'(0));
        out_ready_i = 1'b1;
        for (int i = 100; i < 104; i++) begin
            offer(i, CTRL_W'(i));
            cycle();
            check("recover_data", 128'(out_data_o), 128'(i));
        end
        in_valid_i = 1'b0;

        // Counter saturation on the narrow instance
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_data   = 8'h3c;
        s_in_ctrl   = 4'h2;
        cycle();
        s_in_valid = 1'b0;
        check("sat_load_valid", 128'(s_out_valid), 128'(1));
        check("sat_load_ctrl", 128'(s_out_ctrl), 128'(4'h2));
        check("sat_load_cnt", 128'(s_cnt), 128'(0));
        for (int k = 1; k <= 20; k++) begin
            cycle();
            check("sat_cnt", 128'(s_cnt), 128'((k > 15) ? 15 : k));
        end
        s_out_ready = 1'b1;
        cycle();
        check("sat_drain_valid", 128'(s_out_valid), 128'(0));
        check("sat_drain_ctrl", 128'(s_out_ctrl), 128'(S_BUBBLE));
        check("sat_final_cnt", 128'(s_cnt), 128'(15));

        // Random traffic with occasional flush and reset
        ready_pct = 70;
        for (int n = 0; n < 10000; n++) begin
            if (n % 1000 == 0) ready_pct = int'($urandom_range(10, 95));
            rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_valid_i  = ($urandom_range(0, 99) < 70);
            out_ready_i = ($urandom_range(0, 99) < ready_pct);
            in_data_i   = rnd[DATA_W-1:0];
            in_ctrl_i   = CTRL_W'($urandom());
            flush_i     = ($urandom_range(0, 99) < 2);
            rst_i       = ($urandom_range(0, 999) < 3);
            cycle();
        end
        rst_i   = 1'b0;
        flush_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
